// File: rtl/commu_sweep_ctrl.sv
// Rate-sweep sequencer for the commu link test: holds commu_top in reset, runs one
// transfer per table rate, records pass/fail per rate. Option macro: SWEEP_PATTERN_ALT_EN.
module commu_sweep_ctrl #(
  parameter logic [31:0] TX_COUNT   = 32'd1000,
  parameter logic [15:0] SETTLE_US  = 16'd100,
  parameter logic [31:0] TIMEOUT_US = 32'd1_000_000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        pluse_us,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] rx_total,
  input  logic        rx_error,
  output logic [15:0] tbit_fre,
  output logic [31:0] tx_total,
  output logic        tx_pattern,
  output logic        commu_rst_n,
  output logic [2:0]  step_idx,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pass_mask,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_RECORD = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]  state;
  logic [15:0] settle_cnt;
  logic [31:0] tmo_cnt;
  logic        blank;
  logic        run_ok;
  logic        rec_ok;
  logic        last_run;

`ifdef SWEEP_PATTERN_ALT_EN
  logic first_ok;
  assign rec_ok   = first_ok & run_ok;
  assign last_run = tx_pattern;
`else
  assign rec_ok   = run_ok;
  assign last_run = 1'b1;
`endif

  assign tx_total  = TX_COUNT;
  assign state_dbg = state;

  always_comb begin
    tbit_fre = 16'd10000;
    case (step_idx)
      3'd0: tbit_fre = 16'd10000;
      3'd1: tbit_fre = 16'd5000;
      3'd2: tbit_fre = 16'd2000;
      3'd3: tbit_fre = 16'd1000;
      3'd4: tbit_fre = 16'd500;
      3'd5: tbit_fre = 16'd100;
      3'd6: tbit_fre = 16'd50;
      3'd7: tbit_fre = 16'd10;
      default: tbit_fre = 16'd10000;
    endcase
  end

  // start is a plain level, accepted only in IDLE/DONE; abort wins over everything else.
  // A pulse landing on a state change is loaded into the counter of the state entered.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      settle_cnt  <= 16'd0;
      tmo_cnt     <= 32'd0;
      blank       <= 1'b0;
      run_ok      <= 1'b0;
      step_idx    <= 3'd0;
      pass_mask   <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      commu_rst_n <= 1'b0;
      tx_pattern  <= 1'b0;
`ifdef SWEEP_PATTERN_ALT_EN
      first_ok    <= 1'b0;
`endif
    end else if (abort && state != S_IDLE) begin
      state       <= S_IDLE;
      commu_rst_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_pattern  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_HOLD;
            pass_mask   <= 8'd0;
            done        <= 1'b0;
            step_idx    <= 3'd0;
            busy        <= 1'b1;
            tx_pattern  <= 1'b0;
            commu_rst_n <= 1'b0;
            settle_cnt  <= {15'd0, pluse_us};
          end
        end
        S_HOLD: begin
          if (settle_cnt >= SETTLE_US) begin
            state       <= S_RUN;
            commu_rst_n <= 1'b1;
            tmo_cnt     <= {31'd0, pluse_us};
            blank       <= 1'b1;
          end else if (pluse_us) begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end
        S_RUN: begin
          if (blank) begin
            blank <= 1'b0;
            if (pluse_us) tmo_cnt <= tmo_cnt + 32'd1;
          end else if (rx_error) begin
            run_ok      <= 1'b0;
            state       <= S_RECORD;
            commu_rst_n <= 1'b0;
          end else if (rx_total == TX_COUNT) begin
            run_ok      <= 1'b1;
            state       <= S_RECORD;
            commu_rst_n <= 1'b0;
          end else if (tmo_cnt >= TIMEOUT_US) begin
            run_ok      <= 1'b0;
            state       <= S_RECORD;
            commu_rst_n <= 1'b0;
          end else if (pluse_us) begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        S_RECORD: begin
          if (last_run) begin
            pass_mask[step_idx] <= rec_ok;
            tx_pattern          <= 1'b0;
            if (step_idx == 3'd7) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              step_idx   <= step_idx + 3'd1;
              state      <= S_HOLD;
              settle_cnt <= {15'd0, pluse_us};
            end
          end
`ifdef SWEEP_PATTERN_ALT_EN
          else begin
            // First run of a rate: remember it and repeat with the alternate pattern.
            first_ok   <= run_ok;
            tx_pattern <= 1'b1;
            state      <= S_HOLD;
            settle_cnt <= {15'd0, pluse_us};
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_commu_sweep_ctrl.sv
// Bench for commu_sweep_ctrl: loopback link model, per-cycle output checks against
// a rate-level model, and directed sweeps (pass, error, timeout, abort, reset, alt pattern).
module tb_commu_sweep_ctrl;

  localparam logic [31:0] TX_C    = 32'd1000;
  localparam logic [15:0] SETTLE  = 16'd5;
  localparam logic [31:0] TMO     = 32'd200;
  localparam int          PER     = 4;
  localparam int          LINK_US = 50;
`ifdef SWEEP_PATTERN_ALT_EN
  localparam int RUNS_PER_SWEEP = 16;
`else
  localparam int RUNS_PER_SWEEP = 8;
`endif

  logic        clk_sys = 1'b0;
  logic        rst, pluse_us, start, abort, rx_error;
  logic [31:0] rx_total;
  logic [15:0] tbit_fre;
  logic [31:0] tx_total;
  logic        tx_pattern, commu_rst_n, busy, done;
  logic [2:0]  step_idx, state_dbg;
  logic [7:0]  pass_mask;

  int total = 0;
  int bad = 0;
  int err_step, stuck_step, alt_fail_step;
  int link_us, cyc, runs, run_us, hold_us;
  logic [7:0] exp_mask;
  logic       mask_en, prev_rn;
  logic [15:0] rate_tbl [8] = '{16'd10000, 16'd5000, 16'd2000, 16'd1000,
                                16'd500, 16'd100, 16'd50, 16'd10};

  commu_sweep_ctrl #(.TX_COUNT(TX_C), .SETTLE_US(SETTLE), .TIMEOUT_US(TMO)) dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us), .start(start), .abort(abort),
    .rx_total(rx_total), .rx_error(rx_error), .tbit_fre(tbit_fre), .tx_total(tx_total),
    .tx_pattern(tx_pattern), .commu_rst_n(commu_rst_n), .step_idx(step_idx),
    .busy(busy), .done(done), .pass_mask(pass_mask), .state_dbg(state_dbg)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Expected outcome per rate from the scenario knobs.
  function automatic logic [7:0] calc_mask();
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m[i] = !(i == err_step || i == stuck_step);
`ifdef SWEEP_PATTERN_ALT_EN
      if (i == alt_fail_step) m[i] = 1'b0;
`endif
    end
    return m;
  endfunction

  function automatic logic [7:0] prefix(input logic [2:0] n);
    logic [7:0] m;
    m = 8'd0;
    for (int i = 0; i < 8; i++) if (i < int'(n)) m[i] = exp_mask[i];
    return m;
  endfunction

  // Loopback link: bytes all arrive LINK_US microseconds after release from reset.
  initial begin
    pluse_us = 1'b0;
    link_us = 0;
    cyc = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (!commu_rst_n) link_us = 0;
      else if (pluse_us) link_us++;
      cyc++;
      pluse_us = (cyc % PER == 0);
    end
  end

  always_comb begin
    if (int'(step_idx) == stuck_step) rx_total = 32'd0;
    else if (link_us >= LINK_US) rx_total = TX_C;
    else rx_total = 32'(link_us * 10);
    rx_error = (link_us >= LINK_US) &&
               (int'(step_idx) == err_step || (tx_pattern && int'(step_idx) == alt_fail_step));
  end

  // Per-cycle compare against the rate-level model.
  always @(negedge clk_sys) begin
    if (rst) begin
      prev_rn = 1'b0;
      run_us  = 0;
      hold_us = 0;
    end else begin
      chk("tx_total", tx_total, TX_C);
      chk("tbit_fre", 32'(tbit_fre), 32'(rate_tbl[step_idx]));
      if (mask_en) chk("pass_mask", 32'(pass_mask), 32'(done ? exp_mask : prefix(step_idx)));
      if (done) chk("busy_when_done", 32'(busy), 32'd0);
      if (!busy) chk("link_rst_when_idle", 32'(commu_rst_n), 32'd0);
`ifndef SWEEP_PATTERN_ALT_EN
      chk("tx_pattern", 32'(tx_pattern), 32'd0);
`endif
      if (commu_rst_n && !prev_rn) begin
        chk_rng("hold_us", hold_us, int'(SETTLE) - 1, int'(SETTLE) + 1);
        hold_us = 0;
        run_us = 0;
      end
      if (!commu_rst_n && prev_rn) begin
        if (busy) begin
          chk_rng("run_us", run_us, (int'(step_idx) == stuck_step ? int'(TMO) : LINK_US) - 1,
                  (int'(step_idx) == stuck_step ? int'(TMO) : LINK_US) + 1);
          runs++;
        end
        run_us = 0;
      end
      if (commu_rst_n && pluse_us) run_us++;
      if (busy && !commu_rst_n && pluse_us) hold_us++;
      if (!busy) hold_us = 0;
      prev_rn = commu_rst_n;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst_n"}, 32'(commu_rst_n), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_mask"}, 32'(pass_mask), 32'd0);
    chk({tag, "_step"}, 32'(step_idx), 32'd0);
    chk({tag, "_pattern"}, 32'(tx_pattern), 32'd0);
    chk({tag, "_tbit"}, 32'(tbit_fre), 32'd10000);
    chk({tag, "_tx_total"}, tx_total, 32'd1000);
  endtask

  task automatic begin_sweep(input int e, input int s, input int a);
    mask_en = 1'b0;
    err_step = e;
    stuck_step = s;
    alt_fail_step = a;
    exp_mask = calc_mask();
    runs = 0;
    @(negedge clk_sys);
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    mask_en = 1'b1;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_step", 32'(step_idx), 32'd0);
    chk("start_tbit", 32'(tbit_fre), 32'd10000);
    chk("start_done", 32'(done), 32'd0);
  endtask

  task automatic finish_sweep(input string name, input logic [7:0] lit_mask, input logic poke);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_sys);
      start = (poke && i == 400);
      if (done) begin
        hit = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk({name, "_reached_done"}, 32'(hit), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_mask"}, 32'(pass_mask), 32'(lit_mask));
    chk({name, "_runs"}, runs, RUNS_PER_SWEEP);
  endtask

  initial begin
    logic hit;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    err_step = -1;
    stuck_step = -1;
    alt_fail_step = -1;
    exp_mask = 8'd0;
    mask_en = 1'b0;
    runs = 0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk_reset_vals("reset");
    rst = 1'b0;
    mask_en = 1'b1;
    repeat (3) @(negedge clk_sys);

    // All rates pass; a start mid-sweep must be ignored.
    begin_sweep(-1, -1, -1);
    finish_sweep("all_pass", 8'hFF, 1'b1);

    // rx_error coincides with rx_total == TX_COUNT on rate 3: a fail.
    begin_sweep(3, -1, -1);
    finish_sweep("err_step3", 8'hF7, 1'b0);

    // Rate 0 never completes: timeout after TMO microseconds.
    begin_sweep(-1, 0, -1);
    finish_sweep("timeout_step0", 8'hFE, 1'b0);

    // Abort while running rate 5.
    begin_sweep(-1, -1, -1);
    hit = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_sys);
      if (step_idx == 3'd5 && commu_rst_n) begin
        hit = 1'b1;
        break;
      end
    end
    chk("abort_reached_run5", 32'(hit), 32'd1);
    repeat (3) @(negedge clk_sys);
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rst_n", 32'(commu_rst_n), 32'd0);
    chk("abort_mask", 32'(pass_mask), 32'h1F);
    repeat (20) @(negedge clk_sys);
    chk("abort_stays_idle", 32'(busy), 32'd0);

    // Asynchronous reset while holding at rate 2.
    begin_sweep(-1, -1, -1);
    hit = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_sys);
      if (step_idx == 3'd2 && busy && !commu_rst_n) begin
        hit = 1'b1;
        break;
      end
    end
    chk("rst_reached_hold2", 32'(hit), 32'd1);
    mask_en = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk_sys);
    rst = 1'b0;
    chk_reset_vals("after_rst");
    begin_sweep(-1, -1, -1);
    finish_sweep("after_rst_sweep", 8'hFF, 1'b0);

`ifdef SWEEP_PATTERN_ALT_EN
    // Rate 4 fails only on the alternate pattern.
    begin_sweep(-1, -1, 4);
    finish_sweep("alt_step4", 8'hEF, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
